// File: rtl/cl_pack_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | cl_pack_pkg : shared types and constants for the cache-line packer.  |
// | Revision    : 1.0                                                     |
// +-----------------------------------------------------------------------+
package cl_pack_pkg;

    localparam int DEF_CL_WIDTH   = 512;
    localparam int DEF_WORD_WIDTH = 32;
    localparam int WPL            = DEF_CL_WIDTH / DEF_WORD_WIDTH;
    localparam int IDX_WIDTH      = $clog2(WPL);

    typedef logic [DEF_CL_WIDTH-1:0]   line_t;
    typedef logic [DEF_WORD_WIDTH-1:0] word_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        PUSH = 3'd3,
        DONE = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/cl_line_buf.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | cl_line_buf : one cache-line register with word-slot write, whole-    |
// |               line load and a full flag.   Revision: 1.0              |
// +-----------------------------------------------------------------------+
module cl_line_buf
    import cl_pack_pkg::*;
#(
    parameter int CL_WIDTH   = DEF_CL_WIDTH,
    parameter int WORD_WIDTH = DEF_WORD_WIDTH,
    parameter int IDX_W      = IDX_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en_i,
    input  logic [IDX_W-1:0]      wr_idx_i,
    input  logic [WORD_WIDTH-1:0] wr_word_i,
    input  logic                  set_full_i,
    input  logic                  clr_full_i,
    input  logic                  load_en_i,
    input  logic [CL_WIDTH-1:0]   load_line_i,
    output logic [CL_WIDTH-1:0]   line_o,
    output logic                  full_o
);

    logic [CL_WIDTH-1:0] line_q, line_d;
    logic                full_q, full_d;

    // A load in the same cycle as a clear keeps the buffer full (pop + refill).
    always_comb begin
        line_d = line_q;
        full_d = full_q;
        if (clr_full_i) begin
            full_d = 1'b0;
        end
        if (load_en_i) begin
            line_d = load_line_i;
            full_d = 1'b1;
        end else if (wr_en_i) begin
            line_d[wr_idx_i*WORD_WIDTH +: WORD_WIDTH] = wr_word_i;
        end
        if (set_full_i) begin
            full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_q <= '0;
            full_q <= 1'b0;
        end else begin
            line_q <= line_d;
            full_q <= full_d;
        end
    end

    assign line_o = line_q;
    assign full_o = full_q;

endmodule
`default_nettype wire

// File: rtl/cl_word_packer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | cl_word_packer : reads words from local memory, packs them into cache |
// | lines and pushes them to the DMA write FIFO.                          |
// | Option macro   : CL_PACK_DBUF_EN (double line buffer)                 |
// | Revision       : 1.0                                                  |
// +-----------------------------------------------------------------------+
module cl_word_packer
    import cl_pack_pkg::*;
#(
    parameter int CL_WIDTH    = DEF_CL_WIDTH,
    parameter int WORD_WIDTH  = DEF_WORD_WIDTH,
    parameter int ADDR_WIDTH  = 28,
    parameter int LINES_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  base_addr,
    input  logic [LINES_WIDTH-1:0] num_lines,
    output logic                   mem_en,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    input  logic [WORD_WIDTH-1:0]  mem_data,
    input  logic                   mem_valid,
    input  logic                   host_full,
    output logic                   host_wr_en,
    output logic [CL_WIDTH-1:0]    host_wr_data,
    output logic                   busy,
    output logic                   done
);

    localparam int               WORDS    = CL_WIDTH / WORD_WIDTH;
    localparam int               SLOT_W   = $clog2(WORDS);
    localparam logic [SLOT_W-1:0] LAST_IDX = SLOT_W'(WORDS - 1);

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [SLOT_W-1:0]      idx_q, idx_d;
    logic [LINES_WIDTH-1:0] num_q, num_d;
    logic [LINES_WIDTH-1:0] filled_q, filled_d;
    logic                   zdone_q, zdone_d;

    logic                   w_word_wr;
    logic                   w_last_word;
    logic                   w_push;
    logic [LINES_WIDTH-1:0] w_filled_next;
    logic [CL_WIDTH-1:0]    fill_line;
    logic                   fill_full;

    assign w_word_wr     = (state_q == WAIT) && mem_valid;
    assign w_last_word   = w_word_wr && (idx_q == LAST_IDX);
    assign w_filled_next = filled_q + 1'b1;

`ifdef CL_PACK_DBUF_EN
    logic [LINES_WIDTH-1:0] pushed_q, pushed_d;
    logic [CL_WIDTH-1:0]    out_line;
    logic                   out_full;
    logic                   w_handoff;

    // The fill buffer hands its line over whenever the output slot is free or draining.
    assign w_push    = out_full && !host_full;
    assign w_handoff = (state_q == PUSH) && fill_full && (!out_full || w_push);

    cl_line_buf #(
        .CL_WIDTH   (CL_WIDTH),
        .WORD_WIDTH (WORD_WIDTH),
        .IDX_W      (SLOT_W)
    ) u_fill_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en_i     (w_word_wr),
        .wr_idx_i    (idx_q),
        .wr_word_i   (mem_data),
        .set_full_i  (w_last_word),
        .clr_full_i  (w_handoff),
        .load_en_i   (1'b0),
        .load_line_i ('0),
        .line_o      (fill_line),
        .full_o      (fill_full)
    );

    cl_line_buf #(
        .CL_WIDTH   (CL_WIDTH),
        .WORD_WIDTH (WORD_WIDTH),
        .IDX_W      (SLOT_W)
    ) u_out_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en_i     (1'b0),
        .wr_idx_i    ('0),
        .wr_word_i   ('0),
        .set_full_i  (1'b0),
        .clr_full_i  (w_push),
        .load_en_i   (w_handoff),
        .load_line_i (fill_line),
        .line_o      (out_line),
        .full_o      (out_full)
    );

    assign host_wr_data = out_line;
`else
    logic [CL_WIDTH-1:0] last_q, last_d;

    assign w_push = (state_q == PUSH) && fill_full && !host_full;

    cl_line_buf #(
        .CL_WIDTH   (CL_WIDTH),
        .WORD_WIDTH (WORD_WIDTH),
        .IDX_W      (SLOT_W)
    ) u_fill_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en_i     (w_word_wr),
        .wr_idx_i    (idx_q),
        .wr_word_i   (mem_data),
        .set_full_i  (w_last_word),
        .clr_full_i  (w_push),
        .load_en_i   (1'b0),
        .load_line_i ('0),
        .line_o      (fill_line),
        .full_o      (fill_full)
    );

    // Outside PUSH the fill buffer is being overwritten, so show the last pushed line.
    assign last_d       = w_push ? fill_line : last_q;
    assign host_wr_data = (state_q == PUSH) ? fill_line : last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= '0;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        idx_d    = idx_q;
        num_d    = num_q;
        filled_d = filled_q;
        zdone_d  = 1'b0;
`ifdef CL_PACK_DBUF_EN
        pushed_d = w_push ? pushed_q + 1'b1 : pushed_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (num_lines == '0) begin
                        zdone_d = 1'b1;
                    end else begin
                        num_d    = num_lines;
                        addr_d   = base_addr;
                        idx_d    = '0;
                        filled_d = '0;
`ifdef CL_PACK_DBUF_EN
                        pushed_d = '0;
`endif
                        state_d  = REQ;
                    end
                end
            end
            REQ: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (mem_valid) begin
                    addr_d = addr_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = PUSH;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = REQ;
                    end
                end
            end
            PUSH: begin
`ifdef CL_PACK_DBUF_EN
                // After the final handoff PUSH only waits for the last line to drain.
                if (fill_full) begin
                    if (w_handoff) begin
                        filled_d = w_filled_next;
                        if (w_filled_next != num_q) begin
                            state_d = REQ;
                        end
                    end
                end else if (w_push && (pushed_q + 1'b1 == num_q)) begin
                    state_d = DONE;
                end
`else
                if (w_push) begin
                    filled_d = w_filled_next;
                    state_d  = (w_filled_next == num_q) ? DONE : REQ;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            idx_q    <= '0;
            num_q    <= '0;
            filled_q <= '0;
            zdone_q  <= 1'b0;
`ifdef CL_PACK_DBUF_EN
            pushed_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            idx_q    <= idx_d;
            num_q    <= num_d;
            filled_q <= filled_d;
            zdone_q  <= zdone_d;
`ifdef CL_PACK_DBUF_EN
            pushed_q <= pushed_d;
`endif
        end
    end

    assign mem_en     = (state_q == REQ);
    assign mem_addr   = addr_q;
    assign host_wr_en = w_push;
    assign busy       = (state_q == REQ) || (state_q == WAIT) || (state_q == PUSH);
    assign done       = (state_q == DONE) || zdone_q;

endmodule
`default_nettype wire

// File: doc/cl_word_packer.md
Name: cl_word_packer

Overview:
- Write-back stage between memory_controller and the host DMA write channel.
- Reads num_lines × 16 consecutive 32-bit words from local memory, starting at base_addr.
- Packs each group of 16 words into one 512-bit cache line and pushes it into the DMA write FIFO (dma.wr_en / dma.wr_data), honouring dma.full.
- Replaces the ad-hoc local_rd_en loopback write path in the AFU top.

Parameters:
- CL_WIDTH, 512, cache-line width in bits.
- WORD_WIDTH, 32, memory word width; CL_WIDTH must be a multiple of WORD_WIDTH.
- ADDR_WIDTH, 28, memory word-address width.
- LINES_WIDTH, 16, width of the line-count input.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; latches base_addr and num_lines; ignored unless idle.
- base_addr  in  ADDR_WIDTH  first memory word address.
- num_lines  in  LINES_WIDTH  cache lines to transfer.
- mem_en  out  1  memory read request (to memory_controller DMAEn; DMAWrEn tied 0).
- mem_addr  out  ADDR_WIDTH  read word address.
- mem_data  in  WORD_WIDTH  read data (DMAOut).
- mem_valid  in  1  read data valid (DMAValid); latency ≥1 cycle, variable.
- host_full  in  1  DMA write FIFO full.
- host_wr_en  out  1  push one line into the DMA write FIFO.
- host_wr_data  out  CL_WIDTH  line being pushed.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last line is pushed.

Behaviour:
- Reset (async): state IDLE; mem_en=0; mem_addr=0; host_wr_en=0; host_wr_data=0; busy=0; done=0; word index, line count and line buffer cleared.
- WPL = CL_WIDTH/WORD_WIDTH (16).
- IDLE: on start, if num_lines==0, pulse done next cycle and stay IDLE (busy stays 0). Otherwise latch inputs, set mem_addr=base_addr and go to REQ.
- REQ: mem_en=1 for exactly one cycle, then WAIT.
- WAIT: mem_en=0. On mem_valid, store mem_data into slot [idx*32 +: 32], with word 0 at bits 31:0, and increment mem_addr.
  - If idx != WPL-1: idx++ and go to REQ.
  - Otherwise: idx=0 and go to PUSH.
- One outstanding read at a time; mem_valid outside WAIT is ignored.
- PUSH: when !host_full, assert host_wr_en for one cycle with the full line on host_wr_data, then increment the line count.
  - If lines remain: go to REQ.
  - If none remain: go to DONE.
  - While host_full is high, hold the line and keep host_wr_en low.
- DONE: done=1 for one cycle, busy=0, go to IDLE.
- mem_addr wraps modulo 2^ADDR_WIDTH; no error is flagged.
- host_wr_data holds its last value between pushes.
- start while busy: ignored.
- A start arriving in the same cycle as done is accepted only from IDLE, i.e. the following cycle.
- Reset mid-transfer aborts immediately; no partial line is pushed.

Optional Feature:
- Macro CL_PACK_DBUF_EN.
- Defined: two line buffers. A completed line moves to the output buffer, and filling of the next line (REQ/WAIT) continues while the output buffer waits for !host_full. Filling stalls only when both buffers are full.
- Undefined: single buffer; no memory reads are issued while in PUSH.
- Line ordering, word packing and the done timing relative to the last push are identical in both builds.

Decomposition:
- Package cl_pack_pkg:
  - WPL, IDX_WIDTH = $clog2(WPL).
  - typedef line_t [CL_WIDTH-1:0].
  - typedef word_t [WORD_WIDTH-1:0].
  - enum state_t {IDLE, REQ, WAIT, PUSH, DONE}.
- Sub-module: cl_line_buf, one line register with word-slot write and a full flag. Instantiated once normally, twice under CL_PACK_DBUF_EN.

Test Plan:
- base_addr=0x100, num_lines=1; memory returns data=addr with 2-cycle latency -> 16 reads at 0x100..0x10F; one host_wr_en with host_wr_data[31:0]=0x100 and [511:480]=0x10F; done 1 cycle after the push.
- num_lines=0 -> no mem_en, no host_wr_en; done pulses once; busy stays 0.
- num_lines=3 with host_full held high for 20 cycles at each push -> exactly 3 pushes, each taken only when full=0; data matches addresses 0x000..0x02F.
- base_addr=0xFFFFFF8 (ADDR_WIDTH=28), num_lines=1 -> addresses wrap to 0x0000000..0x0000007 after 0xFFFFFFF.
- rst_n asserted after 5 words of line 0 -> all outputs at reset values immediately; a subsequent start (num_lines=1) produces one clean line.
- With CL_PACK_DBUF_EN, num_lines=2, host_full high for 40 cycles -> second line's reads complete during the stall; both lines pushed in consecutive allowed cycles once full drops.
